edf_cfg_init: RTL and testbench

- Configuration initiator for the EDF interrupt controller.
- Accepts per-interrupt programming commands (id, relative deadline, enable) from a software-facing or sequencer port and buffers them in a small FIFO.
- Serialises each command into controller writes on the cfg_req/cfg_addr/cfg_wdata interface.
- Enforces a minimum idle gap between writes so the controller's serial priority queue can absorb each update.

---
 rtl/edf_ic_pkg.sv | 20 ++
 rtl/edf_cfg_fifo.sv | 58 +++++
 rtl/edf_cfg_init.sv | 129 ++++++++++++
 tb/tb_edf_cfg_init.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/edf_ic_pkg.sv
// Shared constants and types for the EDF interrupt controller configuration path.
package edf_ic_pkg;

    localparam logic [31:0] DL_BASE = 32'h0000_0000;
    localparam logic [31:0] EN_BASE = 32'h0000_0100;

    typedef enum logic [2:0] {
        IDLE,
        WR_DL,
        GAP_DL,
        WR_EN,
        GAP_EN
    } cfg_state_e;

    // Word-aligned register slot for interrupt id within a bank.
    function automatic logic [31:0] slot_addr(input logic [31:0] base, input logic [31:0] id);
        return base + (id << 2);
    endfunction

endpackage

// File: rtl/edf_cfg_fifo.sv
// Synchronous command FIFO; a count one bit wider than the pointers separates full from empty.
module edf_cfg_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem [Depth];
    logic [AddrW-1:0] wr_ptr;
    logic [AddrW-1:0] rd_ptr;
    logic [AddrW:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count == (AddrW + 1)'(Depth));
    assign empty_o = (count == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem[rd_ptr];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AddrW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AddrW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AddrW + 1)'(1);
                2'b01:   count <= count - (AddrW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= data_i;
        end
    end

endmodule

// File: rtl/edf_cfg_init.sv
// Buffers per-interrupt programming commands and serialises each into a deadline
// write and an enable write to the EDF controller, with idle gaps after every write.
module edf_cfg_init
    import edf_ic_pkg::*;
#(
    parameter int unsigned NrParIrqs  = 2,
    parameter int unsigned SerLatency = 1,
    parameter int unsigned FifoDepth  = 4,
    parameter int unsigned DlWidth    = 16,
    localparam int unsigned IdWidth   = $clog2(NrParIrqs)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [IdWidth-1:0] cmd_id_i,
    input  logic [DlWidth-1:0] cmd_deadline_i,
    input  logic               cmd_enable_i,
    output logic               cfg_req_o,
    output logic [31:0]        cfg_addr_o,
    output logic [31:0]        cfg_wdata_o,
    output logic               busy_o,
    output logic               err_o
);

    localparam int unsigned CntW = $clog2(SerLatency + 1);

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [DlWidth-1:0] deadline;
        logic               enable;
    } cfg_cmd_t;

    localparam int unsigned CmdW = $bits(cfg_cmd_t);

    cfg_state_e         state;
    cfg_cmd_t           cmd_in;
    cfg_cmd_t           head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic               head_ok;
    logic [IdWidth-1:0] cur_id;
    logic               cur_en;
    logic [CntW-1:0]    gap_cnt;

    assign cmd_in.id       = cmd_id_i;
    assign cmd_in.deadline = cmd_deadline_i;
    assign cmd_in.enable   = cmd_enable_i;

    edf_cfg_fifo #(
        .Width (CmdW),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (cmd_valid_i),
        .data_i  (cmd_in),
        .pop_i   (fifo_pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign cmd_ready_o = !fifo_full;
    assign fifo_pop    = (state == IDLE) && !fifo_empty;
    assign head_ok     = (32'(head.id) < NrParIrqs);
    assign busy_o      = !fifo_empty || (state != IDLE);

    // Write sequencer: the deadline write is launched on the pop edge itself.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cur_id      <= '0;
            cur_en      <= 1'b0;
            gap_cnt     <= '0;
            cfg_req_o   <= 1'b0;
            cfg_addr_o  <= '0;
            cfg_wdata_o <= '0;
            err_o       <= 1'b0;
        end else begin
            cfg_req_o <= 1'b0;
            err_o     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        cur_id <= head.id;
                        cur_en <= head.enable;
                        if (head_ok) begin
                            cfg_req_o   <= 1'b1;
                            cfg_addr_o  <= slot_addr(DL_BASE, 32'(head.id));
                            cfg_wdata_o <= 32'(head.deadline);
                            state       <= WR_DL;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end
                WR_DL: begin
                    gap_cnt <= CntW'(SerLatency - 1);
                    state   <= GAP_DL;
                end
                GAP_DL: begin
                    if (gap_cnt == '0) begin
                        cfg_req_o   <= 1'b1;
                        cfg_addr_o  <= slot_addr(EN_BASE, 32'(cur_id));
                        cfg_wdata_o <= 32'(cur_en);
                        state       <= WR_EN;
                    end else begin
                        gap_cnt <= gap_cnt - CntW'(1);
                    end
                end
                WR_EN: begin
                    gap_cnt <= CntW'(SerLatency - 1);
                    state   <= GAP_EN;
                end
                GAP_EN: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - CntW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_edf_cfg_init.sv
// Scoreboard bench: two configurations (defaults, and 3 lines / 3-cycle gaps) driven side by side.
module tb_edf_cfg_init;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          gap;
        bit          exact;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst        [2];
    logic        cmd_valid  [2];
    logic        cmd_ready  [2];
    logic [1:0]  cmd_id     [2];
    logic [15:0] cmd_dl     [2];
    logic        cmd_enable [2];
    logic        cfg_req    [2];
    logic [31:0] cfg_addr   [2];
    logic [31:0] cfg_wdata  [2];
    logic        busy       [2];
    logic        err        [2];

    wr_t exp_q [2][$];
    int  err_exp   [2];
    int  err_seen  [2];
    int  ready_low [2];
    int  n_chk  = 0;
    int  n_fail = 0;

    always #5 clk = ~clk;

    function automatic int ser_lat(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic int nirq(input int g);
        return (g == 0) ? 2 : 3;
    endfunction

    function automatic void check(input int g, input bit ok, input string name,
                                  input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL dut%0d %s: got 0x%0h, expected 0x%0h", g, name, act, req);
        end
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned SL = (g == 0) ? 1 : 3;
        localparam int unsigned NI = (g == 0) ? 2 : 3;
        localparam int unsigned IW = $clog2(NI);

        edf_cfg_init #(
            .NrParIrqs  (NI),
            .SerLatency (SL),
            .FifoDepth  (4),
            .DlWidth    (16)
        ) u_dut (
            .clk_i          (clk),
            .rst_i          (rst[g]),
            .cmd_valid_i    (cmd_valid[g]),
            .cmd_ready_o    (cmd_ready[g]),
            .cmd_id_i       (cmd_id[g][IW-1:0]),
            .cmd_deadline_i (cmd_dl[g]),
            .cmd_enable_i   (cmd_enable[g]),
            .cfg_req_o      (cfg_req[g]),
            .cfg_addr_o     (cfg_addr[g]),
            .cfg_wdata_o    (cfg_wdata[g]),
            .busy_o         (busy[g]),
            .err_o          (err[g])
        );

        int  gap;
        bit  have_prev;
        wr_t e;

        // Monitor: every strobe pops one expected write and checks its spacing.
        always @(negedge clk) begin
            if (rst[g]) begin
                have_prev = 1'b0;
                gap       = 0;
            end else begin
                if (err[g]) err_seen[g]++;
                if (cfg_req[g]) begin
                    check(g, exp_q[g].size() != 0, "strobe_expected", cfg_addr[g], 32'hFFFF_FFFF);
                    if (exp_q[g].size() != 0) begin
                        e = exp_q[g].pop_front();
                        check(g, cfg_addr[g] == e.addr, "addr", cfg_addr[g], e.addr);
                        check(g, cfg_wdata[g] == e.data, "wdata", cfg_wdata[g], e.data);
                        if (have_prev) begin
                            if (e.exact) check(g, gap == e.gap, "gap_exact", 32'(gap), 32'(e.gap));
                            else         check(g, gap >= e.gap, "gap_min", 32'(gap), 32'(e.gap));
                        end
                    end
                    have_prev = 1'b1;
                    gap       = 0;
                end else begin
                    gap++;
                end
            end
        end
    end

    // Reference model: a command is two writes into fixed banks, or an error if the id is out of range.
    task automatic model(input int g, input logic [1:0] id, input logic [15:0] dl,
                         input logic en, input bit queued);
        wr_t e;
        if (int'(id) >= nirq(g)) begin
            err_exp[g]++;
        end else begin
            e.addr  = 32'(id) * 4;
            e.data  = 32'(dl);
            e.gap   = ser_lat(g) + 1;
            e.exact = queued;
            exp_q[g].push_back(e);
            e.addr  = 32'h100 + 32'(id) * 4;
            e.data  = 32'(en);
            e.gap   = ser_lat(g);
            e.exact = 1'b1;
            exp_q[g].push_back(e);
        end
    endtask

    task automatic send(input int g, input logic [1:0] id, input logic [15:0] dl,
                        input logic en, input bit queued);
        int n = 0;
        bit acc = 1'b0;
        cmd_valid[g]  = 1'b1;
        cmd_id[g]     = id;
        cmd_dl[g]     = dl;
        cmd_enable[g] = en;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = cmd_ready[g];
            if (!acc) ready_low[g]++;
            @(posedge clk);
            n++;
        end
        #1 cmd_valid[g] = 1'b0;
        check(g, acc, "accept_timeout", 32'(n), 32'd200);
        if (acc) model(g, id, dl, en, queued);
    endtask

    task automatic wait_idle(input int g);
        int  n = 0;
        bit  done = 1'b0;
        while (!done && n < 2000) begin
            @(posedge clk);
            #1;
            done = (exp_q[g].size() == 0) && !busy[g];
            n++;
        end
        check(g, done, "drain_timeout", 32'(exp_q[g].size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   k;
        int   g;
        bit   found;
        logic [1:0] rid;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; cmd_valid[i] = 1'b0; cmd_id[i] = '0; cmd_dl[i] = '0;
            cmd_enable[i] = 1'b0; err_exp[i] = 0; err_seen[i] = 0; ready_low[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check(i, cmd_ready[i] == 1'b1, "rst_ready", 32'(cmd_ready[i]), 32'd1);
            check(i, cfg_req[i] == 1'b0, "rst_req", 32'(cfg_req[i]), 32'd0);
            check(i, busy[i] == 1'b0, "rst_busy", 32'(busy[i]), 32'd0);
            check(i, err[i] == 1'b0, "rst_err", 32'(err[i]), 32'd0);
            check(i, cfg_addr[i] == 32'd0, "rst_addr", cfg_addr[i], 32'd0);
            check(i, cfg_wdata[i] == 32'd0, "rst_wdata", cfg_wdata[i], 32'd0);
            rst[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;

        // Single command with defaults: latency and busy fall.
        send(0, 2'd1, 16'h00AB, 1'b1, 1'b0);
        @(posedge clk); #1;
        check(0, cfg_req[0] == 1'b1, "dl_strobe_latency", 32'(cfg_req[0]), 32'd1);
        repeat (2) @(posedge clk); #1;
        check(0, cfg_req[0] == 1'b1, "en_strobe_latency", 32'(cfg_req[0]), 32'd1);
        @(posedge clk); #1;
        check(0, busy[0] == 1'b1, "busy_in_gap", 32'(busy[0]), 32'd1);
        @(posedge clk); #1;
        check(0, busy[0] == 1'b0, "busy_fall", 32'(busy[0]), 32'd0);
        wait_idle(0);

        // Back-to-back burst fills the FIFO and must drain in order.
        ready_low[0] = 0;
        for (int i = 0; i < 6; i++)
            send(0, 2'(i % 2), 16'($urandom), 1'($urandom), i > 0);
        check(0, ready_low[0] > 0, "full_backpressure", 32'(ready_low[0]), 32'd1);
        wait_idle(0);

        // Long gaps: exact spacing within and between queued commands.
        for (int i = 0; i < 4; i++)
            send(1, 2'(i % 3), 16'($urandom), 1'($urandom), i > 0);
        wait_idle(1);

        // Out-of-range id is dropped with a single error pulse.
        send(1, 2'd3, 16'h1234, 1'b1, 1'b0);
        send(1, 2'd2, 16'hBEEF, 1'b1, 1'b0);
        wait_idle(1);
        check(1, err_seen[1] == err_exp[1], "err_pulses", 32'(err_seen[1]), 32'(err_exp[1]));

        // Reset during a deadline write with commands still queued.
        for (int i = 0; i < 4; i++)
            send(0, 2'(i % 2), 16'(16'h100 + i), 1'b1, i > 0);
        found = 1'b0;
        k = 0;
        while (!found && k < 100) begin
            @(posedge clk); #1;
            found = cfg_req[0] && (cfg_addr[0] < 32'h100);
            k++;
        end
        check(0, found, "find_wr_dl", 32'(k), 32'd100);
        rst[0] = 1'b1;
        #1;
        check(0, cfg_req[0] == 1'b0, "rst_mid_req", 32'(cfg_req[0]), 32'd0);
        check(0, cmd_ready[0] == 1'b1, "rst_mid_ready", 32'(cmd_ready[0]), 32'd1);
        check(0, busy[0] == 1'b0, "rst_mid_empty", 32'(busy[0]), 32'd0);
        exp_q[0].delete();
        @(posedge clk); #1;
        rst[0] = 1'b0;
        @(posedge clk); #1;
        send(0, 2'd0, 16'h0042, 1'b0, 1'b0);
        wait_idle(0);

        // Randomised traffic on both configurations, including bad ids on the 3-line one.
        for (int i = 0; i < 40; i++) begin
            g   = int'($urandom_range(0, 1));
            rid = 2'($urandom_range(0, (g == 0) ? 1 : 3));
            send(g, rid, 16'($urandom), 1'($urandom), 1'b0);
            repeat ($urandom_range(0, 6)) @(posedge clk);
            #1;
        end
        wait_idle(0);
        wait_idle(1);
        for (int i = 0; i < 2; i++) begin
            check(i, err_seen[i] == err_exp[i], "err_total", 32'(err_seen[i]), 32'(err_exp[i]));
            check(i, exp_q[i].size() == 0, "queue_empty", 32'(exp_q[i].size()), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
